uart_frame_tx: RTL and testbench

//  UART transmitter: serialises one parallel frame into start bit, FRAME_WD data bits (LSB first),

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_tx_if.sv | 21 ++
 rtl/uart_frame_tx_baud_gen.sv | 36 +++
 rtl/uart_frame_tx.sv | 134 +++++++++++++
 tb/tb_uart_frame_tx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: one-hot FSM state
// encoding, parity-mode constants and a constant-evaluable clog2 helper.
package uart_pkg;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_START_BIT  = 5'b00010,
    S_DATA_FRAME = 5'b00100,
    S_PARITY_BIT = 5'b01000,
    S_STOP_BIT   = 5'b10000
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Host-side handshake of the UART transmitter plus the serial line.
// master = host logic driving frames, slave = the transmitter itself.
interface uart_frame_tx_if #(
  parameter int FRAME_WD = 8
);
  logic                frame_en;
  logic [FRAME_WD-1:0] data_frame;
  logic                tx_busy;
  logic                tx_done;
  logic                uart_tx;

  modport master (
    output frame_en, data_frame,
    input  tx_busy, tx_done, uart_tx
  );

  modport slave (
    input  frame_en, data_frame,
    output tx_busy, tx_done, uart_tx
  );
endinterface

// File: rtl/uart_frame_tx_baud_gen.sv
// Bit-period timer: counts BAUD_DIV clocks while enabled and flags the last
// cycle of every bit. Disabling clears the count, so each frame starts on a
// fresh bit boundary with no phase left over from the previous one.
module tx_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cnt_en,
  output logic o_bit_tick
);

  localparam int BAUD_DIV = CLK_FREQUENCE / BAUD_RATE;
  localparam int CNT_W    = clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = i_cnt_en && (r_cnt == CNT_MAX);

  // Free-running bit-period counter, held at zero while disabled.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_cnt_en || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, FRAME_WD data bits LSB first, optional
// parity bit, stop bit(s). uart_tx is registered and idles high.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (default one).
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BAUD_RATE     = 9600,
  parameter string PARITY        = "NONE",
  parameter int    FRAME_WD      = 8
) (
  input logic            clk,
  input logic            rst_n,
  uart_frame_tx_if.slave tx_if
);

  localparam int PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                            (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int BIT_W = clog2(FRAME_WD);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(FRAME_WD - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(NSTOP - 1);

  tx_state_e           r_state;
  tx_state_e           w_state_nxt;
  logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_WD-1:0] r_shift, w_shift_nxt;
  logic                r_parity, w_parity_nxt;
  logic                r_uart_tx, w_tx_nxt;
  logic                w_bit_tick;
  logic                w_done;
  logic                w_accept;

  tx_baud_gen #(
    .CLK_FREQUENCE (CLK_FREQUENCE),
    .BAUD_RATE     (BAUD_RATE)
  ) u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cnt_en   (r_state != S_IDLE),
    .o_bit_tick (w_bit_tick)
  );

  // The done cycle already counts as idle, so a new frame can chain with no gap.
  assign w_done   = (r_state == S_STOP_BIT) && w_bit_tick && (r_bit_cnt == LAST_STOP);
  assign w_accept = tx_if.frame_en && ((r_state == S_IDLE) || w_done);

  assign tx_if.tx_done = w_done;
  assign tx_if.tx_busy = (r_state != S_IDLE) && !w_done;
  assign tx_if.uart_tx = r_uart_tx;

  // Next-state, bit counter, shift register and line value for the coming cycle.
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    if (w_accept) begin
      w_state_nxt   = S_START_BIT;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = tx_if.data_frame;
      w_parity_nxt  = (PAR_MODE == PAR_ODD) ? ~^tx_if.data_frame : ^tx_if.data_frame;
    end else begin
      case (r_state)
        S_START_BIT: begin
          if (w_bit_tick) begin
            w_state_nxt   = S_DATA_FRAME;
            w_bit_cnt_nxt = '0;
          end
        end
        S_DATA_FRAME: begin
          if (w_bit_tick) begin
            w_shift_nxt = r_shift >> 1;
            if (r_bit_cnt == LAST_DATA) begin
              w_state_nxt   = (PAR_MODE != PAR_NONE) ? S_PARITY_BIT : S_STOP_BIT;
              w_bit_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY_BIT: begin
          if (w_bit_tick) begin
            w_state_nxt   = S_STOP_BIT;
            w_bit_cnt_nxt = '0;
          end
        end
        S_STOP_BIT: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              w_state_nxt   = S_IDLE;
              w_bit_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Line value follows the state being entered, so uart_tx changes on the
    // same edge as the FSM.
    case (w_state_nxt)
      S_START_BIT:  w_tx_nxt = 1'b0;
      S_DATA_FRAME: w_tx_nxt = w_shift_nxt[0];
      S_PARITY_BIT: w_tx_nxt = w_parity_nxt;
      default:      w_tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and output register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_uart_tx <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_uart_tx <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx with BAUD_DIV=16: three instances (NONE, EVEN,
// ODD parity) checked cycle by cycle against a bit-list model of the frame.
module tb_uart_frame_tx;

  localparam int CLK_F = 16;
  localparam int BAUD  = 1;
  localparam int BD    = CLK_F / BAUD;
  localparam int W     = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic clk;
  logic rst_n;
  logic         fe   [3];
  logic [W-1:0] din  [3];
  logic         tx   [3];
  logic         busy [3];
  logic         done [3];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_frame_tx_if #(.FRAME_WD(W)) if_none ();
  uart_frame_tx_if #(.FRAME_WD(W)) if_even ();
  uart_frame_tx_if #(.FRAME_WD(W)) if_odd  ();

  assign if_none.frame_en   = fe[0];
  assign if_none.data_frame = din[0];
  assign if_even.frame_en   = fe[1];
  assign if_even.data_frame = din[1];
  assign if_odd.frame_en    = fe[2];
  assign if_odd.data_frame  = din[2];
  assign tx[0] = if_none.uart_tx;  assign busy[0] = if_none.tx_busy;  assign done[0] = if_none.tx_done;
  assign tx[1] = if_even.uart_tx;  assign busy[1] = if_even.tx_busy;  assign done[1] = if_even.tx_done;
  assign tx[2] = if_odd.uart_tx;   assign busy[2] = if_odd.tx_busy;   assign done[2] = if_odd.tx_done;

  uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("NONE"), .FRAME_WD(W))
    u_none (.clk(clk), .rst_n(rst_n), .tx_if(if_none));
  uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("EVEN"), .FRAME_WD(W))
    u_even (.clk(clk), .rst_n(rst_n), .tx_if(if_even));
  uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("ODD"), .FRAME_WD(W))
    u_odd  (.clk(clk), .rst_n(rst_n), .tx_if(if_odd));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit period.
  // k selects the parity mode: 0 none, 1 even, 2 odd.
  task automatic build_frame(input int k, input logic [W-1:0] d, output logic q[$]);
    int ones;
    q = {};
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (k == 1) q.push_back((ones % 2) == 1);
    if (k == 2) q.push_back((ones % 2) == 0);
    for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
  endtask

  // Called at a negedge with instance k idle: presents a frame for one edge.
  task automatic start(input int k, input logic [W-1:0] d);
    fe[k]  = 1'b1;
    din[k] = d;
    @(negedge clk);
  endtask

  // Entered at the negedge of cycle 1 after acceptance. Checks line, busy and
  // done every cycle up to stop_c; at cycle inj_c frame_en is raised with inj_d.
  task automatic check_frame(input int k, input logic [W-1:0] d, input int inj_c,
                             input logic [W-1:0] inj_d, input int stop_c);
    logic q[$];
    int   len;
    build_frame(k, d, q);
    len = q.size() * BD;
    for (int c = 1; c <= len; c++) begin
      if (c > stop_c) break;
      fe[k] = (c == inj_c);
      if (c == inj_c) din[k] = inj_d;
      check($sformatf("tx k%0d d%02h c%0d", k, d, c), 32'(tx[k]), 32'(q[(c-1)/BD]));
      check($sformatf("busy k%0d d%02h c%0d", k, d, c), 32'(busy[k]), 32'(c < len));
      check($sformatf("done k%0d d%02h c%0d", k, d, c), 32'(done[k]), 32'(c == len));
      @(negedge clk);
    end
    fe[k] = 1'b0;
  endtask

  task automatic check_idle(input int k, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      check($sformatf("%s tx c%0d", tag, c), 32'(tx[k]), 32'd1);
      check($sformatf("%s busy c%0d", tag, c), 32'(busy[k]), 32'd0);
      check($sformatf("%s done c%0d", tag, c), 32'(done[k]), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int           len0;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fe[k]  = 1'b0;
      din[k] = '0;
    end
    len0 = (1 + W + NSTOP) * BD;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst tx k%0d", k), 32'(tx[k]), 32'd1);
      check($sformatf("rst busy k%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("rst done k%0d", k), 32'(done[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, 4, "idle0");

    // No parity, 0xA5
    start(0, 8'hA5);
    check_frame(0, 8'hA5, 0, '0, 1 << 20);

    // Even parity 0xA5 / 0xA4, odd parity 0xA5
    start(1, 8'hA5);
    check_frame(1, 8'hA5, 0, '0, 1 << 20);
    start(1, 8'hA4);
    check_frame(1, 8'hA4, 0, '0, 1 << 20);
    start(2, 8'hA5);
    check_frame(2, 8'hA5, 0, '0, 1 << 20);

    // frame_en mid-frame is ignored
    start(0, 8'h3C);
    check_frame(0, 8'h3C, 50, 8'hFF, 1 << 20);
    check_idle(0, 20, "after_ignore");

    // frame_en in the tx_done cycle chains with no idle gap
    start(0, 8'h12);
    check_frame(0, 8'h12, len0, 8'h34, 1 << 20);
    check_frame(0, 8'h34, 0, '0, 1 << 20);
    check_idle(0, 3, "after_chain");

    // Asynchronous reset at cycle 50 of a frame
    d = 8'($urandom);
    start(0, d);
    check_frame(0, d, 0, '0, 49);
    #1 rst_n = 1'b0;
    #1;
    check("async rst tx", 32'(tx[0]), 32'd1);
    check("async rst busy", 32'(busy[0]), 32'd0);
    check("async rst done", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, 2 * BD, "after_rst");
    d = 8'($urandom);
    start(0, d);
    check_frame(0, d, 0, '0, 1 << 20);

    // Random frames on every parity flavour, some chained back to back
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        logic [W-1:0] d2;
        int           len;
        logic         q[$];
        d  = 8'($urandom);
        d2 = 8'($urandom);
        build_frame(k, d, q);
        len = q.size() * BD;
        start(k, d);
        if ($urandom_range(1) == 1) begin
          check_frame(k, d, len, d2, 1 << 20);
          check_frame(k, d2, 0, '0, 1 << 20);
        end else begin
          check_frame(k, d, 0, '0, 1 << 20);
        end
        check_idle(k, 2, $sformatf("rand_idle k%0d", k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
